// File: rtl/cpr_pkg.sv
// cpr_pkg: shared types for the issue stage (entry layout, FSM states, width helper)
package cpr_pkg;
  localparam int CPR_TW = 2;
  localparam int CPR_FDSSI_W = 12;
  localparam int CPR_SSI_W = 8;
  localparam int CPR_SW = 2;
  typedef struct packed {
    logic [CPR_FDSSI_W-1:0] fdssi;
    logic [CPR_TW-1:0] fdsti;
    logic [CPR_SSI_W-1:0] ssi;
    logic [CPR_SW-1:0] s;
  } cpr_entry_t;
  typedef enum logic [0:0] {RUN, FLUSH} cpr_state_t;
  function automatic int ENTRY_W(input int tw, input int fdssi_w, input int ssi_w, input int sw);
    return tw + fdssi_w + ssi_w + sw;
  endfunction
endpackage

// File: rtl/cpr_issue_fifo.sv
// cpr_issue_fifo: DEPTH x W register FIFO with push/pop/flush; head is the registered slot at rd_ptr
module cpr_issue_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/cpr_issue.sv
// cpr_issue: registered issue stage after the min-s comparator tree; FIFO, one-hot grant, held-winner watchdog.
// Optional same-cycle bypass when empty: define CPR_ISSUE_BYPASS_EN.
module cpr_issue import cpr_pkg::*; #(
  parameter int TW = CPR_TW,
  parameter int FDSSI_W = CPR_FDSSI_W,
  parameter int SSI_W = CPR_SSI_W,
  parameter int SW = CPR_SW,
  parameter int DEPTH = 4,
  parameter int WT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_valid,
  input  logic               win_wt,
  input  logic [FDSSI_W-1:0] win_fdssi,
  input  logic [TW-1:0]      win_fdsti,
  input  logic [SSI_W-1:0]   win_ssi,
  input  logic [SW-1:0]      win_s,
  output logic [2**TW-1:0]   grant,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FDSSI_W-1:0] out_fdssi,
  output logic [TW-1:0]      out_fdsti,
  output logic [SSI_W-1:0]   out_ssi,
  output logic [SW-1:0]      out_s,
  output logic               stall_err
);
  localparam int EW = ENTRY_W(TW, FDSSI_W, SSI_W, SW);
  localparam int NW = 2**TW;
  typedef struct packed {
    logic [FDSSI_W-1:0] fdssi;
    logic [TW-1:0] fdsti;
    logic [SSI_W-1:0] ssi;
    logic [SW-1:0] s;
  } entry_t;
  entry_t win_e, head_e, out_e;
  cpr_state_t state;
  logic [7:0] wt_cnt;
  logic full, empty, fifo_pop, accept, push, held, byp;
  assign win_e = {win_fdssi, win_fdsti, win_ssi, win_s};
  assign held = win_valid & win_wt;
  assign fifo_pop = ~empty & out_ready;
  // rst_n gates accept so grant drops the moment reset asserts
  assign accept = rst_n & win_valid & ~win_wt & (~full | fifo_pop) & (state == RUN) & ~flush;
  assign grant = accept ? NW'(1) << win_fdsti : '0;
`ifdef CPR_ISSUE_BYPASS_EN
  assign byp = accept & empty & out_ready;
`else
  assign byp = 1'b0;
`endif
  assign push = accept & ~byp;
  assign out_valid = ~empty | byp;
  assign out_e = byp ? win_e : head_e;
  assign {out_fdssi, out_fdsti, out_ssi, out_s} = out_e;
  cpr_issue_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(fifo_pop),
    .flush(flush),
    .din(win_e),
    .dout(head_e),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wt_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      state <= flush ? FLUSH : RUN;
      wt_cnt <= !held ? '0 : (wt_cnt == 8'(WT_MAX)) ? wt_cnt : wt_cnt + 8'd1;
      if (held && wt_cnt == 8'(WT_MAX)) stall_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cpr_issue.sv
// tb_cpr_issue: directed + random stimulus against a queue-based reference model of cpr_issue
module tb_cpr_issue;
  localparam int DEPTH = 4;
  localparam int WT_MAX = 15;
  typedef struct packed {
    logic [11:0] fdssi;
    logic [1:0] fdsti;
    logic [7:0] ssi;
    logic [1:0] s;
  } ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic win_valid = 0, win_wt = 0, flush = 0, out_ready = 0;
  logic [11:0] win_fdssi = '0;
  logic [1:0] win_fdsti = '0, win_s = '0;
  logic [7:0] win_ssi = '0;
  logic [3:0] grant;
  logic out_valid, stall_err;
  logic [11:0] out_fdssi;
  logic [1:0] out_fdsti, out_s;
  logic [7:0] out_ssi;
  int vecs = 0, errs = 0;
  ent_t q[$];
  ent_t cur;
  bit in_flush = 0, stall = 0, exp_acc = 0;
  int held = 0;

  cpr_issue #(.TW(2), .FDSSI_W(12), .SSI_W(8), .SW(2), .DEPTH(DEPTH), .WT_MAX(WT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_wt(win_wt),
    .win_fdssi(win_fdssi), .win_fdsti(win_fdsti), .win_ssi(win_ssi), .win_s(win_s),
    .grant(grant), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_fdssi(out_fdssi), .out_fdsti(out_fdsti), .out_ssi(out_ssi), .out_s(out_s),
    .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set(input bit v, input bit wt, input logic [1:0] idx, input logic [1:0] key, input bit rdy, input bit fl);
    win_valid = v;
    win_wt = wt;
    win_fdsti = idx;
    win_s = key;
    win_fdssi = 12'($urandom);
    win_ssi = 8'($urandom);
    out_ready = rdy;
    flush = fl;
  endtask

  task automatic settle();
    #2;
    cur = '{fdssi: win_fdssi, fdsti: win_fdsti, ssi: win_ssi, s: win_s};
    exp_acc = rst_n && win_valid && !win_wt && !in_flush && !flush &&
              (q.size() < DEPTH || (q.size() > 0 && out_ready));
    chk("grant", grant, exp_acc ? (32'd1 << win_fdsti) : 32'd0);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_fdssi", out_fdssi, q[0].fdssi);
      chk("out_fdsti", out_fdsti, q[0].fdsti);
      chk("out_ssi", out_ssi, q[0].ssi);
      chk("out_s", out_s, q[0].s);
    end
    chk("stall_err", stall_err, stall);
  endtask

  task automatic tick();
    @(posedge clk);
    if (flush) begin
      q.delete();
      in_flush = 1;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (exp_acc) q.push_back(cur);
      in_flush = 0;
    end
    if (win_valid && win_wt) begin
      held++;
      if (held > WT_MAX) stall = 1;
    end else held = 0;
    @(negedge clk);
  endtask

  task automatic step(input bit v, input bit wt, input logic [1:0] idx, input logic [1:0] key, input bit rdy, input bit fl);
    set(v, wt, idx, key, rdy, fl);
    settle();
    tick();
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_stall", stall_err, 0);
    chk("rst_fields", {out_fdssi, out_fdsti, out_ssi, out_s}, 0);
    @(negedge clk);
    rst_n = 1;
    // single winner: same-cycle grant, head visible next cycle
    set(1, 0, 2, 1, 1, 0);
    settle();
    chk("t1_grant", grant, 4'b0100);
    tick();
    set(0, 0, 0, 0, 1, 0);
    settle();
    chk("t1_fdsti", out_fdsti, 2);
    chk("t1_s", out_s, 1);
    tick();
    // fill with consumer stalled, fifth waits until a pop frees a slot
    for (int i = 0; i < 5; i++) step(1, 0, 2'(i), 2'(i), 0, 0);
    step(1, 0, 3, 2, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // push and pop together while full
    for (int i = 0; i < 4; i++) step(1, 0, 2'(i), 2'(i + 1), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2'(i + 1), 2'(i), 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // held winner: 15 cycles is fine, the 16th trips the watchdog
    for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 1, 0);
    chk("t3_no_err_15", stall_err, 0);
    set(1, 1, 1, 0, 1, 0);
    settle();
    chk("t3_grant_held", grant, 0);
    tick();
    chk("t3_err_16", stall_err, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    // flush with 3 queued and a winner offered
    for (int i = 0; i < 3; i++) step(1, 0, 2'(i), 2'(i), 0, 0);
    step(1, 0, 1, 1, 0, 1);
    set(1, 0, 2, 2, 0, 0);
    settle();
    chk("t4_flush_grant", grant, 0);
    chk("t4_flush_valid", out_valid, 0);
    tick();
    step(1, 0, 3, 3, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(7) == 0, 2'($urandom), 2'($urandom),
           $urandom_range(1) == 1, $urandom_range(31) == 0);
    // reset in the middle of a stream
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 2'(i), 2'(i), 0, 0);
    set(1, 0, 3, 1, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_grant", grant, 0);
    chk("t6_stall", stall_err, 0);
    q.delete();
    in_flush = 0;
    held = 0;
    stall = 0;
    @(negedge clk);
    rst_n = 1;
    set(1, 0, 2, 1, 1, 0);
    settle();
    chk("t6_grant_after", grant, 4'b0100);
    tick();
    set(0, 0, 0, 0, 1, 0);
    settle();
    chk("t6_fdsti", out_fdsti, 2);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
